// File: rtl/dawn_loader_pkg.sv
// dawn_loader_pkg: shared ASCII constants, loader states and error codes
package dawn_loader_pkg;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_NL   = 8'h0A;
    localparam logic [7:0] CH_CR   = 8'h0D;
    typedef enum logic [2:0] {
        S_IDLE, S_FIRST, S_COMMENT, S_LSTART, S_LO_NIB, S_EOL, S_DONE, S_ERR
    } state_t;
    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_HDR   = 3'd1;
    localparam logic [2:0] E_CHAR  = 3'd2;
    localparam logic [2:0] E_TRUNC = 3'd3;
    localparam logic [2:0] E_MEM   = 3'd4;
    localparam logic [2:0] E_MARK  = 3'd5;
endpackage

// File: rtl/hex_ascii_decode.sv
// hex_ascii_decode: maps an ASCII character to a hex nibble plus a validity flag
module hex_ascii_decode (
    input  logic [7:0] char_i,
    output logic       is_hex_o,
    output logic [3:0] nib_o
);
    logic       digit;
    logic       alpha;
    logic [7:0] lower;
    // Setting bit 5 folds 'A'..'F' onto 'a'..'f'
    assign lower    = char_i | 8'h20;
    assign digit    = char_i >= 8'h30 && char_i <= 8'h39;
    assign alpha    = lower >= 8'h61 && lower <= 8'h66;
    assign is_hex_o = digit | alpha;
    assign nib_o    = digit ? char_i[3:0] : char_i[3:0] + 4'd9;
endmodule

// File: rtl/hex_program_loader.sv
// hex_program_loader: parses an ASCII hex image into byte-RAM writes and
// records the start address of every instruction in a mark table
module hex_program_loader
    import dawn_loader_pkg::*;
#(
    parameter int  ADDR_W = 10,
    parameter int  MARK_N = 16,
    localparam int MARK_W = $clog2(MARK_N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              char_valid_i,
    output logic              char_ready_o,
    input  logic [7:0]        char_i,
    input  logic              char_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mark_we_o,
    output logic [MARK_W-1:0] mark_idx_o,
    output logic [ADDR_W-1:0] mark_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        err_code_o,
    output logic [ADDR_W:0]   byte_count_o
);
    state_t              state_q, state_d;
    logic [3:0]          hi_q, hi_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [MARK_W:0]     idx_q, idx_d;
    logic [2:0]          code_q, code_d, e;
    logic                ready_q, err_q;
    logic                mem_we_q, mem_we_d, mark_we_q, mark_we_d, done_q, done_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d, kaddr_q, kaddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [MARK_W-1:0]   kidx_q, kidx_d;
    logic                is_hex, acc;
    logic [3:0]          nib;

    hex_ascii_decode u_dec (.char_i(char_i), .is_hex_o(is_hex), .nib_o(nib));

    assign acc = char_valid_i & ready_q & ~start_i;

    always_comb begin
        e         = E_NONE;
        state_d   = state_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        code_d    = code_q;
        mem_we_d  = 1'b0;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        mark_we_d = 1'b0;
        kidx_d    = kidx_q;
        kaddr_d   = kaddr_q;
        done_d    = 1'b0;
        if (start_i) begin
            state_d = S_FIRST;
            cnt_d   = '0;
            idx_d   = '0;
            code_d  = E_NONE;
        end else if (acc) begin
            if (char_i != CH_CR) case (state_q)
                S_FIRST:   if (char_i == CH_HASH) state_d = S_COMMENT; else e = E_HDR;
                S_COMMENT: if (char_i == CH_NL) begin
                    state_d = S_LSTART;
                    if (idx_q == (MARK_W+1)'(MARK_N)) e = E_MARK;
                    else begin
                        mark_we_d = 1'b1;
                        kidx_d    = idx_q[MARK_W-1:0];
                        kaddr_d   = cnt_q[ADDR_W-1:0];
                        idx_d     = idx_q + (MARK_W+1)'(1);
                    end
                end
                S_LSTART:  if (char_i == CH_HASH) state_d = S_COMMENT;
                    else if (is_hex) begin
                        hi_d    = nib;
                        state_d = S_LO_NIB;
                    end else if (char_i != CH_NL) e = E_CHAR;
                S_LO_NIB:  if (!is_hex) e = E_CHAR;
                    else if (cnt_q[ADDR_W]) e = E_MEM;
                    else begin
                        mem_we_d = 1'b1;
                        maddr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d  = {hi_q, nib};
                        cnt_d    = cnt_q + (ADDR_W+1)'(1);
                        state_d  = S_EOL;
                    end
                S_EOL:     if (char_i == CH_NL) state_d = S_LSTART; else e = E_CHAR;
                default: ;
            endcase
            // The final char is judged by the state it leaves behind
            if (char_last_i && e == E_NONE) begin
                if (state_d == S_LSTART || state_d == S_EOL) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else e = E_TRUNC;
            end
            if (e != E_NONE) begin
                state_d = S_ERR;
                code_d  = e;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            code_q    <= E_NONE;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            mem_we_q  <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            mark_we_q <= 1'b0;
            kidx_q    <= '0;
            kaddr_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            code_q    <= code_d;
            ready_q   <= state_d inside {S_FIRST, S_COMMENT, S_LSTART, S_LO_NIB, S_EOL};
            err_q     <= code_d != E_NONE;
            mem_we_q  <= mem_we_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            mark_we_q <= mark_we_d;
            kidx_q    <= kidx_d;
            kaddr_q   <= kaddr_d;
            done_q    <= done_d;
        end

    assign char_ready_o = ready_q;
    assign busy_o       = ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = maddr_q;
    assign mem_wdata_o  = wdata_q;
    assign mark_we_o    = mark_we_q;
    assign mark_idx_o   = kidx_q;
    assign mark_addr_o  = kaddr_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = code_q;
    assign byte_count_o = cnt_q;
endmodule

// File: tb/tb_hex_program_loader.sv
// tb_hex_program_loader: directed images checked cycle by cycle against a
// character-level model of the image format, plus literal end-of-load checks
module tb_hex_program_loader;
    localparam int  DEPTH = 4;
    localparam int  MN    = 4;
    localparam byte HASH  = 8'h23;
    localparam byte NL    = 8'h0A;
    localparam byte CR    = 8'h0D;

    logic       clk = 1'b0, rst, start, cv, cl;
    logic [7:0] ch;
    logic       char_ready_o, mem_we_o, mark_we_o, busy_o, done_o, err_o;
    logic [1:0] mem_addr_o, mark_idx_o, mark_addr_o;
    logic [7:0] mem_wdata_o;
    logic [2:0] err_code_o, byte_count_o;

    hex_program_loader #(.ADDR_W(2), .MARK_N(MN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .char_valid_i(cv),
        .char_ready_o(char_ready_o), .char_i(ch), .char_last_i(cl),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mark_we_o(mark_we_o), .mark_idx_o(mark_idx_o), .mark_addr_o(mark_addr_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .byte_count_o(byte_count_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic chk_en = 1'b0;
    logic       e_we, e_mwe, e_done, e_busy;
    logic [1:0] e_addr, e_midx, e_maddr;
    logic [7:0] e_data;
    logic [2:0] e_code, e_cnt;

    bit         w_at[64], m_at[64], done_at[64], busy_at[64];
    int         wa[64], mi[64], ma[64], code_at[64], cnt_at[64];
    logic [7:0] wd[64];
    int         nacc;

    int         we_cnt, mark_cnt, done_cnt;
    logic [7:0] mem_img[4];
    logic [1:0] last_midx, last_maddr;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, a, x, $time);
        end
    endtask

    function automatic int hexv(input byte c);
        int v = int'(c);
        if (v >= 48 && v <= 57) return v - 48;
        if (v >= 65 && v <= 70) return v - 55;
        if (v >= 97 && v <= 102) return v - 87;
        return -1;
    endfunction

    // Walks the image char by char and records what every accepted char must cause
    function automatic void model(input string s, input bit last);
        int ph = 0, cnt = 0, mk = 0, code = 0, hi = 0, h;
        byte c;
        nacc = s.len();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            h = hexv(c);
            w_at[i] = 0; m_at[i] = 0; done_at[i] = 0;
            if (c != CR) begin
                if (ph == 0) begin
                    if (c == HASH) ph = 1; else code = 1;
                end else if (ph == 1) begin
                    if (c == NL) begin
                        if (mk == MN) code = 5;
                        else begin m_at[i] = 1; mi[i] = mk; ma[i] = cnt; mk++; end
                        ph = 2;
                    end
                end else if (ph == 2) begin
                    if (c == HASH) ph = 1;
                    else if (h >= 0) begin hi = h; ph = 3; end
                    else if (c != NL) code = 2;
                end else if (ph == 3) begin
                    if (h < 0) code = 2;
                    else if (cnt == DEPTH) code = 4;
                    else begin w_at[i] = 1; wa[i] = cnt; wd[i] = 8'(hi * 16 + h); cnt++; ph = 4; end
                end else begin
                    if (c == NL) ph = 2; else code = 2;
                end
            end
            if (code == 0 && last && i == s.len() - 1) begin
                if (ph == 2 || ph == 4) done_at[i] = 1; else code = 3;
            end
            code_at[i] = code;
            cnt_at[i]  = cnt;
            busy_at[i] = code == 0 && !done_at[i];
            if (code != 0) begin nacc = i + 1; break; end
        end
    endfunction

    always @(negedge clk) if (chk_en) begin
        chk("mem_we", mem_we_o, e_we);
        if (e_we) begin
            chk("mem_addr", mem_addr_o, e_addr);
            chk("mem_wdata", mem_wdata_o, e_data);
        end
        chk("mark_we", mark_we_o, e_mwe);
        if (e_mwe) begin
            chk("mark_idx", mark_idx_o, e_midx);
            chk("mark_addr", mark_addr_o, e_maddr);
        end
        chk("done", done_o, e_done);
        chk("busy", busy_o, e_busy);
        chk("ready", char_ready_o, e_busy);
        chk("err", err_o, e_code != 0);
        chk("err_code", err_code_o, e_code);
        chk("byte_count", byte_count_o, e_cnt);
        if (mem_we_o) begin we_cnt++; mem_img[mem_addr_o] = mem_wdata_o; end
        if (mark_we_o) begin mark_cnt++; last_midx = mark_idx_o; last_maddr = mark_addr_o; end
        if (done_o) done_cnt++;
    end

    task automatic clr_obs();
        we_cnt = 0; mark_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) mem_img[i] = 8'h00;
    endtask

    task automatic tick_idle();
        @(posedge clk); #2;
        e_we = 0; e_mwe = 0; e_done = 0;
    endtask

    task automatic apply(input int i);
        e_we = w_at[i]; e_addr = 2'(wa[i]); e_data = wd[i];
        e_mwe = m_at[i]; e_midx = 2'(mi[i]); e_maddr = 2'(ma[i]);
        e_done = done_at[i]; e_busy = busy_at[i];
        e_code = 3'(code_at[i]); e_cnt = 3'(cnt_at[i]);
    endtask

    task automatic send_char(input int i, input byte c, input bit lst);
        int t = 0;
        cv = 1; ch = c; cl = lst;
        while (!char_ready_o && t < 20) begin tick_idle(); t++; end
        if (!char_ready_o) begin
            total++; bad++;
            $display("FAIL handshake char=%0d ready=0 want=1", i);
        end else begin
            @(posedge clk); #2;
            apply(i);
        end
        cv = 0; cl = 0;
    endtask

    task automatic run_image(input string s, input bit last, input int limit, input bit gaps);
        int n;
        model(s, last);
        n = limit < nacc ? limit : nacc;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick_idle();
            send_char(i, s[i], last && i == s.len() - 1);
        end
    endtask

    task automatic start_load(input bit withc, input byte c);
        start = 1; cv = withc; ch = c;
        @(posedge clk); #2;
        start = 0; cv = 0;
        e_we = 0; e_mwe = 0; e_done = 0; e_busy = 1; e_code = 0; e_cnt = 0;
    endtask

    initial begin
        rst = 1; start = 0; cv = 0; cl = 0; ch = 0;
        e_we = 0; e_mwe = 0; e_done = 0; e_busy = 0; e_code = 0; e_cnt = 0;
        e_addr = 0; e_midx = 0; e_maddr = 0; e_data = 0;
        clr_obs();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", char_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err_code", err_code_o, 0);
        chk("rst_byte_count", byte_count_o, 0);
        rst = 0; chk_en = 1;
        tick_idle();

        start_load(0, 8'h00); clr_obs();
        run_image("#a\n01\n02\n#b\n03\n", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t1_writes", we_cnt, 3);
        chk("t1_marks", mark_cnt, 2);
        chk("t1_done", done_cnt, 1);
        chk("t1_byte2", mem_img[2], 8'h03);
        chk("t1_mark1_addr", last_maddr, 2);
        chk("t1_count", byte_count_o, 3);
        chk("t1_err", err_o, 0);

        start_load(0, 8'h00); clr_obs();
        run_image("X#\n", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t2_code", err_code_o, 1);
        chk("t2_ready", char_ready_o, 0);
        chk("t2_writes", we_cnt + mark_cnt, 0);

        start_load(0, 8'h00); clr_obs();
        run_image("#\n0G", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t3_marks", mark_cnt, 1);
        chk("t3_code", err_code_o, 2);
        chk("t3_writes", we_cnt, 0);

        start_load(0, 8'h00); clr_obs();
        run_image("#\n01\n02\n03\n04\n05\n", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t4_writes", we_cnt, 4);
        chk("t4_byte3", mem_img[3], 8'h04);
        chk("t4_code", err_code_o, 4);
        chk("t4_count", byte_count_o, 4);

        start_load(0, 8'h00); clr_obs();
        run_image("#x\015\nab\015\n", 1, 99, 1);
        repeat (2) tick_idle();
        chk("t5_byte0", mem_img[0], 8'hAB);
        chk("t5_marks", mark_cnt, 1);
        chk("t5_done", done_cnt, 1);

        start_load(0, 8'h00); clr_obs();
        run_image("#\n7", 0, 99, 0);
        rst = 1;
        e_we = 0; e_mwe = 0; e_done = 0; e_busy = 0; e_code = 0; e_cnt = 0;
        #1;
        chk("t6_rst_addr", mem_addr_o, 0);
        chk("t6_rst_mark", {mark_idx_o, mark_addr_o}, 0);
        repeat (2) tick_idle();
        rst = 0;
        tick_idle();
        chk("t6_no_write", we_cnt, 0);

        start_load(0, 8'h00);
        run_image("#\n12", 0, 99, 0);
        start_load(1, NL); clr_obs();
        chk("t6_abort_count", byte_count_o, 0);
        run_image("#\n99\n", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t6_reload", mem_img[0], 8'h99);
        chk("t6_reload_writes", we_cnt, 1);
        start_load(0, 8'h00);
        run_image("#\n1", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t6_trunc", err_code_o, 3);

        start_load(0, 8'h00); clr_obs();
        run_image("#\n#\n#\n#\n#\n", 1, 99, 0);
        repeat (2) tick_idle();
        chk("t7_marks", mark_cnt, 4);
        chk("t7_last_idx", last_midx, 3);
        chk("t7_code", err_code_o, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
